calc_mem_responder: RTL and testbench

- Memory-side responder for the calculator's cmd/address/data interface.
- Holds a 256x32 word store shared by the PS register port and the PL calculator port.
- Sequences each session through three phases: PS load, PL compute, PS readback.
- Generates the calculator's ready input and consumes its done_pl output.

---
 rtl/calc_mem_responder_pkg.sv | 22 ++
 rtl/calc_mem_responder_if.sv | 38 +++
 rtl/calc_mem_responder_ram.sv | 37 +++
 rtl/calc_mem_responder.sv | 141 ++++++++++++++
 tb/tb_calc_mem_responder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_mem_responder_pkg.sv
// Shared definitions for the calculator memory responder and the calculator:
// command encodings, session state enum and default slot map.
package calc_mem_pkg;

    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] CMD_READ  = 3'd3;
    localparam logic [2:0] CMD_IDLE  = 3'd4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_ADDR_W       = 8;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_OPERAND_ADDR = 255;
    localparam int DEF_INSTR_BASE   = 1;
    localparam int DEF_INSTR_NUM    = 5;
    localparam int DEF_RESULT_BASE  = 6;

endpackage

// File: rtl/calc_mem_responder_if.sv
// PL calculator bus plus PS register bus as seen by the memory responder.
// slave = responder side, master = calculator / PS host side.
interface calc_mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // PL calculator port
    logic [2:0]        pl_cmd;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_wdata;
    logic [DATA_W-1:0] pl_rdata;
    logic              pl_ready;
    logic              pl_done;
    // PS register port
    logic              ps_we;
    logic              ps_re;
    logic [ADDR_W-1:0] ps_addr;
    logic [DATA_W-1:0] ps_wdata;
    logic [DATA_W-1:0] ps_rdata;
    logic              ps_rvalid;
    logic              ps_err;
    logic              ps_done;
    logic              ps_clear;

    modport slave (
        input  pl_cmd, pl_addr, pl_wdata, pl_done,
        input  ps_we, ps_re, ps_addr, ps_wdata, ps_clear,
        output pl_rdata, pl_ready,
        output ps_rdata, ps_rvalid, ps_err, ps_done
    );

    modport master (
        output pl_cmd, pl_addr, pl_wdata, pl_done,
        output ps_we, ps_re, ps_addr, ps_wdata, ps_clear,
        input  pl_rdata, pl_ready,
        input  ps_rdata, ps_rvalid, ps_err, ps_done
    );
endinterface

// File: rtl/calc_mem_responder_ram.sv
// calc_mem_ram: one write port, two registered read ports (PL side A, PS side B).
// Storage has no reset so it maps onto block RAM; only the read registers reset.
// A read and write to the same address in one cycle returns the old word.
module calc_mem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Single write port, storage not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered reads; each port holds its last value when not enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) rdata_a <= mem[raddr_a];
            if (re_b) rdata_b <= mem[raddr_b];
        end
    end
endmodule

// File: rtl/calc_mem_responder.sv
// calc_mem_responder: memory-side responder for the calculator. Sequences a
// session through LOAD (PS fills operand + instruction slots), BUSY (PL
// computes, writes results) and DONE (PS reads back, ps_clear restarts).
// Optional macro CALC_MEM_GUARD_EN: drop PL writes in BUSY that fall outside
// the result window and flag them on sticky output pl_guard_err.
module calc_mem_responder
    import calc_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int OPERAND_ADDR = DEF_OPERAND_ADDR,
    parameter int INSTR_BASE   = DEF_INSTR_BASE,
    parameter int INSTR_NUM    = DEF_INSTR_NUM,
    parameter int RESULT_BASE  = DEF_RESULT_BASE
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_mem_responder_if.slave  bus
`ifdef CALC_MEM_GUARD_EN
    , output logic               pl_guard_err
`endif
);
    // bit 0 = operand word, bits 1..INSTR_NUM = instruction slots
    localparam int MASK_W = INSTR_NUM + 1;

    state_t            state;
    logic [MASK_W-1:0] load_mask;
    logic [MASK_W-1:0] load_hit;
    logic [MASK_W-1:0] mask_next;
    logic              ps_load;
    logic              pl_wr_req;
    logic              pl_write;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              pl_ready_q;
    logic              ps_rvalid_q;
    logic              ps_err_q;
    logic              ps_done_q;

    // Which load-mask bit a PS write address corresponds to (addresses wrap).
    always_comb begin
        load_hit = '0;
        if (bus.ps_addr == ADDR_W'(OPERAND_ADDR)) load_hit[0] = 1'b1;
        for (int i = 0; i < INSTR_NUM; i++) begin
            if (bus.ps_addr == ADDR_W'(INSTR_BASE + i)) load_hit[i+1] = 1'b1;
        end
    end

    assign ps_load   = (state == LOAD) && bus.ps_we;
    assign pl_wr_req = (state == BUSY) && (bus.pl_cmd == CMD_WRITE);
    assign mask_next = load_mask | (ps_load ? load_hit : '0);

`ifdef CALC_MEM_GUARD_EN
    logic pl_in_window;
    assign pl_in_window = (int'(bus.pl_addr) >= RESULT_BASE) &&
                          (int'(bus.pl_addr) <  RESULT_BASE + INSTR_NUM);
    assign pl_write     = pl_wr_req && pl_in_window;

    // Sticky flag for PL writes outside the result window; ps_clear wipes it.
    always_ff @(posedge clk) begin
        if (rst || bus.ps_clear) pl_guard_err <= 1'b0;
        else if (pl_wr_req && !pl_in_window) pl_guard_err <= 1'b1;
    end
`else
    assign pl_write = pl_wr_req;
`endif

    // PS owns the write port in LOAD, PL in BUSY; the states never overlap.
    assign mem_we    = ps_load || pl_write;
    assign mem_waddr = ps_load ? bus.ps_addr  : bus.pl_addr;
    assign mem_wdata = ps_load ? bus.ps_wdata : bus.pl_wdata;

    calc_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .re_a    (bus.pl_cmd == CMD_READ),
        .raddr_a (bus.pl_addr),
        .rdata_a (bus.pl_rdata),
        .re_b    (bus.ps_re),
        .raddr_b (bus.ps_addr),
        .rdata_b (bus.ps_rdata)
    );

    // Session FSM with registered handshake outputs. A write completing the
    // mask lands the same cycle the state moves to BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            load_mask   <= '0;
            pl_ready_q  <= 1'b0;
            ps_done_q   <= 1'b0;
            ps_rvalid_q <= 1'b0;
            ps_err_q    <= 1'b0;
        end else begin
            ps_rvalid_q <= bus.ps_re;
            ps_err_q    <= (state == BUSY) && bus.ps_we;
            case (state)
                LOAD: begin
                    load_mask <= mask_next;
                    if (&mask_next) begin
                        state      <= BUSY;
                        pl_ready_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.pl_done) begin
                        state      <= DONE;
                        pl_ready_q <= 1'b0;
                        ps_done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.ps_clear) begin
                        state     <= LOAD;
                        load_mask <= '0;
                        ps_done_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= LOAD;
                    load_mask  <= '0;
                    pl_ready_q <= 1'b0;
                    ps_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pl_ready  = pl_ready_q;
    assign bus.ps_rvalid = ps_rvalid_q;
    assign bus.ps_err    = ps_err_q;
    assign bus.ps_done   = ps_done_q;

endmodule

// File: tb/tb_calc_mem_responder.sv
// Self-checking bench for calc_mem_responder: table-driven slot loading plus
// hand sequences for BUSY/DONE/clear/reset; PS reads checked via a scoreboard.
module tb_calc_mem_responder;
    import calc_mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calc_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus ();
`ifdef CALC_MEM_GUARD_EN
    logic pl_guard_err;
`endif

    calc_mem_responder dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus)
`ifdef CALC_MEM_GUARD_EN
        , .pl_guard_err (pl_guard_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mdl [256];
    logic [31:0] exp_q [$];

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        exp_ready;
    } load_vec_t;
    load_vec_t lv [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every ps_rvalid pops one expected word.
    always @(negedge clk) begin
        if (bus.ps_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("ps_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                chk("ps_rdata", bus.ps_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic drain(input string nm);
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            chk({nm, "_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic ps_write(input logic [7:0] a, input logic [31:0] d, input bit upd);
        bus.ps_we    = 1'b1;
        bus.ps_addr  = a;
        bus.ps_wdata = d;
        tick();
        bus.ps_we    = 1'b0;
        if (upd) mdl[a] = d;
    endtask

    task automatic ps_read(input logic [7:0] a);
        bus.ps_re   = 1'b1;
        bus.ps_addr = a;
        exp_q.push_back(mdl[a]);
        tick();
        chk("ps_rvalid_pulse", 32'(bus.ps_rvalid), 32'd1);
        bus.ps_re = 1'b0;
        drain("ps_read");
        tick();
        chk("ps_rvalid_low", 32'(bus.ps_rvalid), 32'd0);
    endtask

    task automatic pl_write(input logic [7:0] a, input logic [31:0] d);
        bus.pl_cmd   = CMD_WRITE;
        bus.pl_addr  = a;
        bus.pl_wdata = d;
        tick();
        bus.pl_cmd   = CMD_IDLE;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_pl_rdata"},  bus.pl_rdata, 32'd0);
        chk({nm, "_ps_rdata"},  bus.ps_rdata, 32'd0);
        chk({nm, "_pl_ready"},  32'(bus.pl_ready), 32'd0);
        chk({nm, "_ps_rvalid"}, 32'(bus.ps_rvalid), 32'd0);
        chk({nm, "_ps_err"},    32'(bus.ps_err), 32'd0);
        chk({nm, "_ps_done"},   32'(bus.ps_done), 32'd0);
    endtask

    task automatic load_table(input string nm);
        for (int i = 0; i < 7; i++) begin
            ps_write(lv[i].addr, lv[i].data, 1'b1);
            chk($sformatf("%s_ready_%0d", nm, i), 32'(bus.pl_ready), 32'(lv[i].exp_ready));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lv[0] = '{8'd255, 32'h7654_3210, 1'b0};
        lv[1] = '{8'd1,   32'd0,         1'b0};
        lv[2] = '{8'd2,   32'd1,         1'b0};
        lv[3] = '{8'd3,   32'd2,         1'b0};
        lv[4] = '{8'd4,   32'd3,         1'b0};
        lv[5] = '{8'd2,   32'd1,         1'b0};  // rewrite, still four slots
        lv[6] = '{8'd5,   32'd4,         1'b1};

        bus.pl_cmd = CMD_IDLE; bus.pl_addr = '0; bus.pl_wdata = '0; bus.pl_done = 1'b0;
        bus.ps_we = 1'b0; bus.ps_re = 1'b0; bus.ps_addr = '0; bus.ps_wdata = '0;
        bus.ps_clear = 1'b0;
        rst = 1'b1;
        tick(); tick();
        chk_reset_outs("reset");
        rst = 1'b0;

        // Non-slot words used later; no mask bits
        ps_write(8'd7,  32'h0707_0707, 1'b1);
        ps_write(8'd10, 32'h0000_A5A5, 1'b1);
        chk("nonslot_ready", 32'(bus.pl_ready), 32'd0);

        // Read-before-write on the same address
        bus.ps_re = 1'b1; bus.ps_we = 1'b1; bus.ps_addr = 8'd10; bus.ps_wdata = 32'h0000_5A5A;
        exp_q.push_back(mdl[10]);
        mdl[10] = 32'h0000_5A5A;
        tick();
        bus.ps_re = 1'b0; bus.ps_we = 1'b0;
        drain("rbw");
        ps_read(8'd10);

        // PL write in LOAD is ignored
        pl_write(8'd10, 32'hFFFF_FFFF);
        ps_read(8'd10);

        load_table("load1");

        // PL read held three cycles
        bus.pl_cmd = CMD_READ; bus.pl_addr = 8'd255;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("pl_rdata_c%0d", c + 2), bus.pl_rdata, 32'h7654_3210);
        end
        bus.pl_cmd = CMD_IDLE; bus.pl_addr = 8'd6;
        tick();
        chk("pl_rdata_hold", bus.pl_rdata, 32'h7654_3210);

        // PL result write, PS readback
        pl_write(8'd6, 32'h0000_00AB);
        mdl[6] = 32'h0000_00AB;
        ps_read(8'd6);

        // PS write rejected in BUSY
        ps_write(8'd7, 32'h1234_5678, 1'b0);
        chk("ps_err_pulse", 32'(bus.ps_err), 32'd1);
        tick();
        chk("ps_err_low", 32'(bus.ps_err), 32'd0);
        ps_read(8'd7);

        // ps_clear outside DONE is ignored
        bus.ps_clear = 1'b1; tick(); bus.ps_clear = 1'b0;
        chk("clear_busy_ready", 32'(bus.pl_ready), 32'd1);
        chk("clear_busy_done", 32'(bus.ps_done), 32'd0);

        // Out-of-window PL write
        pl_write(8'd3, 32'h0000_0BAD);
`ifdef CALC_MEM_GUARD_EN
        chk("guard_set", 32'(pl_guard_err), 32'd1);
`else
        mdl[3] = 32'h0000_0BAD;
`endif
        ps_read(8'd3);
        pl_write(8'd10, 32'h0000_0010);
        mdl[10] = 32'h0000_0010;
        ps_read(8'd10);
`ifdef CALC_MEM_GUARD_EN
        chk("guard_sticky", 32'(pl_guard_err), 32'd1);
`endif
        pl_write(8'd9, 32'h0000_0099);
        mdl[9] = 32'h0000_0099;

        // PL write together with pl_done is still performed
        bus.pl_cmd = CMD_WRITE; bus.pl_addr = 8'd8; bus.pl_wdata = 32'h0000_0088; bus.pl_done = 1'b1;
        tick();
        bus.pl_cmd = CMD_IDLE; bus.pl_done = 1'b0;
        mdl[8] = 32'h0000_0088;
        chk("done_ready", 32'(bus.pl_ready), 32'd0);
        chk("done_ps_done", 32'(bus.ps_done), 32'd1);
        ps_read(8'd8);

        // PL write in DONE is ignored
        pl_write(8'd9, 32'h0000_00EE);
        ps_read(8'd9);
        chk("done_level", 32'(bus.ps_done), 32'd1);

        // New session: mask cleared, one write is not enough
        bus.ps_clear = 1'b1; tick(); bus.ps_clear = 1'b0;
        chk("clear_ps_done", 32'(bus.ps_done), 32'd0);
        chk("clear_ready", 32'(bus.pl_ready), 32'd0);
`ifdef CALC_MEM_GUARD_EN
        chk("guard_cleared", 32'(pl_guard_err), 32'd0);
`endif
        ps_write(8'd255, 32'h7654_3210, 1'b1);
        chk("clear_one_write", 32'(bus.pl_ready), 32'd0);
        tick();
        chk("clear_one_write2", 32'(bus.pl_ready), 32'd0);

        load_table("load2");

        // Reset mid-BUSY: outputs back to reset values, memory kept, mask cleared
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset_outs("midrst");
        ps_write(8'd255, 32'h0000_1357, 1'b1);
        chk("midrst_reload", 32'(bus.pl_ready), 32'd0);
        ps_read(8'd6);
        ps_read(8'd255);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
